// File: rtl/proc_dir_sched.sv
// Direction turnaround scheduler for bidirectional proc plugin channels: one shared
// dead-time timer, granted round-robin. Optional input stability filter: PROC_DIR_SCHED_FILTER_EN.
module proc_dir_sched #(
    parameter int                NUM_CH      = 4,
    parameter int                DEAD_CYCLES = 3,
    parameter logic [NUM_CH-1:0] RESET_DIR   = '0,
    localparam int               IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] dir_req,
    output logic [NUM_CH-1:0] output_enable,
    output logic [NUM_CH-1:0] input_enable,
    output logic [NUM_CH-1:0] dir_state,
    output logic              busy,
    output logic [IDX_W-1:0]  grant_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEAD,
        S_COMMIT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_timer;
    logic [IDX_W-1:0]  r_grant;
    logic [IDX_W-1:0]  r_rr;
    logic              r_target;
    logic              r_busy;
    logic [NUM_CH-1:0] r_oe;
    logic [NUM_CH-1:0] r_ie;
    logic [NUM_CH-1:0] r_dir;

    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_pend;
    logic              w_found;
    logic [IDX_W-1:0]  w_gnt;
    int                w_best_d;
    int                w_d;

`ifdef PROC_DIR_SCHED_FILTER_EN
    // A raw bit is accepted only once it matches its value from the previous cycle.
    logic [NUM_CH-1:0] r_req_h0;
    logic [NUM_CH-1:0] r_req_flt;
    logic [NUM_CH-1:0] w_stable;

    assign w_stable = ~(dir_req ^ r_req_h0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_h0  <= RESET_DIR;
            r_req_flt <= RESET_DIR;
        end else begin
            r_req_h0  <= dir_req;
            r_req_flt <= (dir_req & w_stable) | (r_req_flt & ~w_stable);
        end
    end

    assign w_req = r_req_flt;
`else
    assign w_req = dir_req;
`endif

    assign w_pend = w_req ^ r_dir;

    // Round-robin pick: the pending channel with the smallest forward distance from r_rr.
    always_comb begin
        w_found  = 1'b0;
        w_gnt    = '0;
        w_best_d = NUM_CH;
        w_d      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_d = (i >= int'(r_rr)) ? (i - int'(r_rr)) : (i + NUM_CH - int'(r_rr));
            if (w_pend[i] && (w_d < w_best_d)) begin
                w_best_d = w_d;
                w_gnt    = IDX_W'(i);
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_found) w_state_nxt = S_DEAD;
            S_DEAD:   if (r_timer == 8'd0) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_timer  <= 8'd0;
            r_grant  <= '0;
            r_rr     <= '0;
            r_target <= 1'b0;
            r_busy   <= 1'b0;
            r_oe     <= RESET_DIR;
            r_ie     <= ~RESET_DIR;
            r_dir    <= RESET_DIR;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_busy       <= 1'b1;
                        r_grant      <= w_gnt;
                        r_target     <= w_req[w_gnt];
                        r_oe[w_gnt]  <= 1'b0;
                        r_ie[w_gnt]  <= 1'b0;
                        r_timer      <= 8'(DEAD_CYCLES - 1);
                    end
                end
                S_DEAD: begin
                    // New enables land on the cycle after the last dead cycle.
                    if (r_timer == 8'd0) begin
                        r_dir[r_grant] <= r_target;
                        r_oe[r_grant]  <= r_target;
                        r_ie[r_grant]  <= ~r_target;
                    end else begin
                        r_timer <= r_timer - 8'd1;
                    end
                end
                S_COMMIT: begin
                    r_busy <= 1'b0;
                    r_rr   <= (r_grant == IDX_W'(NUM_CH - 1)) ? '0 : r_grant + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign output_enable = r_oe;
    assign input_enable  = r_ie;
    assign dir_state     = r_dir;
    assign busy          = r_busy;
    assign grant_idx     = r_grant;

endmodule

// File: tb/tb_proc_dir_sched.sv
// Directed bench for proc_dir_sched (NUM_CH=4, DEAD_CYCLES=3, RESET_DIR=0).
module tb_proc_dir_sched;

    logic       clk;
    logic       rst;
    logic [3:0] dir_req;
    logic [3:0] output_enable;
    logic [3:0] input_enable;
    logic [3:0] dir_state;
    logic       busy;
    logic [1:0] grant_idx;

    int n_vec  = 0;
    int n_miss = 0;
    bit mon_en = 0;

    proc_dir_sched #(
        .NUM_CH     (4),
        .DEAD_CYCLES(3),
        .RESET_DIR  (4'b0000)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .dir_req      (dir_req),
        .output_enable(output_enable),
        .input_enable (input_enable),
        .dir_state    (dir_state),
        .busy         (busy),
        .grant_idx    (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        dir_req = 4'b0000;
        step();
        step();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) chk("no_overlap", {28'd0, output_enable & input_enable}, 32'd0);
    end

    logic [3:0] exp3_dir [4];
    logic [1:0] exp3_g   [4];

    initial begin
        exp3_dir = '{4'b0100, 4'b1100, 4'b1101, 4'b1111};
        exp3_g   = '{2'd2, 2'd3, 2'd0, 2'd1};
        rst      = 1'b1;
        dir_req  = 4'b0000;

        // Test 1: idle after reset
        do_reset();
        mon_en = 1;
        chk("rst_dir", {28'd0, dir_state}, 32'h0);
        chk("rst_grant", {30'd0, grant_idx}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            chk("t1_oe", {28'd0, output_enable}, 32'h0);
            chk("t1_ie", {28'd0, input_enable}, 32'hf);
            chk("t1_busy", {31'd0, busy}, 32'd0);
            step();
        end

        // Test 2: single request on ch1
        dir_req = 4'b0010;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("t2_oe1", {31'd0, output_enable[1]}, 32'd0);
            chk("t2_ie1", {31'd0, input_enable[1]}, 32'd0);
            chk("t2_busy", {31'd0, busy}, 32'd1);
            chk("t2_grant", {30'd0, grant_idx}, 32'd1);
        end
        step();
        chk("t2_oe", {28'd0, output_enable}, 32'h2);
        chk("t2_ie", {28'd0, input_enable}, 32'hd);
        chk("t2_dir", {28'd0, dir_state}, 32'h2);
        step();
        chk("t2_idle", {31'd0, busy}, 32'd0);
        dir_req = 4'b0000;
        repeat (5) step();
        chk("t2_back_dir", {28'd0, dir_state}, 32'h0);
        chk("t2_back_ie", {28'd0, input_enable}, 32'hf);
        chk("t2_back_busy", {31'd0, busy}, 32'd0);

        // Test 3: all four at once, rr_ptr now 2
        dir_req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                step();
                chk("t3_grant", {30'd0, grant_idx}, {30'd0, exp3_g[k]});
                chk("t3_busy", {31'd0, busy}, 32'd1);
                chk("t3_lowmask", {28'd0, ~output_enable & ~input_enable},
                    32'd1 << exp3_g[k]);
            end
            step();
            chk("t3_dir", {28'd0, dir_state}, {28'd0, exp3_dir[k]});
            chk("t3_oe", {28'd0, output_enable}, {28'd0, exp3_dir[k]});
            step();
            chk("t3_idle", {31'd0, busy}, 32'd0);
            chk("t3_nolow", {28'd0, ~output_enable & ~input_enable}, 32'h0);
        end

        // Test 4: drop request during DEAD, latched target still commits
        do_reset();
        dir_req = 4'b0001;
        step();
        chk("t4_grant", {30'd0, grant_idx}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        dir_req = 4'b0000;
        step();
        step();
        chk("t4_dead_oe", {28'd0, output_enable}, 32'h0);
        chk("t4_dead_ie", {28'd0, input_enable}, 32'he);
        step();
        chk("t4_dir_out", {28'd0, dir_state}, 32'h1);
        chk("t4_oe_out", {28'd0, output_enable}, 32'h1);
        step();
        chk("t4_idle", {31'd0, busy}, 32'd0);
        step();
        chk("t4_regrant", {31'd0, busy}, 32'd1);
        chk("t4_regrant_g", {30'd0, grant_idx}, 32'd0);
        chk("t4_regrant_ie", {28'd0, input_enable}, 32'he);
        repeat (3) step();
        chk("t4_dir_in", {28'd0, dir_state}, 32'h0);
        chk("t4_ie_in", {28'd0, input_enable}, 32'hf);
        chk("t4_oe_in", {28'd0, output_enable}, 32'h0);

        // Test 5: reset mid-turnaround on ch3
        do_reset();
        dir_req = 4'b1000;
        step();
        chk("t5_grant", {30'd0, grant_idx}, 32'd3);
        step();
        rst     = 1'b1;
        dir_req = 4'b0000;
        step();
        chk("t5_oe", {28'd0, output_enable}, 32'h0);
        chk("t5_ie", {28'd0, input_enable}, 32'hf);
        chk("t5_dir", {28'd0, dir_state}, 32'h0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_gidx", {30'd0, grant_idx}, 32'd0);
        rst = 1'b0;
        repeat (4) step();
        chk("t5_nocommit", {28'd0, dir_state}, 32'h0);
        chk("t5_quiet", {31'd0, busy}, 32'd0);

`ifdef PROC_DIR_SCHED_FILTER_EN
        // Test 6: glitch rejected, held request granted two cycles late
        do_reset();
        dir_req = 4'b0100;
        step();
        dir_req = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t6_glitch", {31'd0, busy}, 32'd0);
        end
        dir_req = 4'b0100;
        step();
        chk("t6b_w1", {31'd0, busy}, 32'd0);
        step();
        chk("t6b_w2", {31'd0, busy}, 32'd0);
        step();
        chk("t6b_w3", {31'd0, busy}, 32'd1);
        chk("t6b_g", {30'd0, grant_idx}, 32'd2);
`endif

        mon_en = 0;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
